judge_unit: RTL

Per-lane hit judgement for the 4-key rhythm game. Sits between the PS/2 key decoder, which supplies four lane key levels, and the score/combo outputs that feed the display. Chart notes are pushed in with a timestamp and queued per lane. Key presses are compared against the oldest queued note in that lane and graded PERFECT, GOOD or MISS, and score and combo are updated from the grade.

---
 rtl/judge_unit.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/judge_unit.sv
// -----------------------------------------------------------------------------
// judge_unit
//
// Per-lane hit judgement for the 4-key rhythm game. Chart notes are queued per
// lane with their hit time. Rising key edges are compared against the oldest
// queued note of their lane and graded PERFECT / GOOD / MISS. Score and combo
// are updated from each grade.
//
// Parameters
//   PERFECT_WIN  max |song_time - note_time| (ms) graded PERFECT
//   GOOD_WIN     max |song_time - note_time| (ms) graded GOOD (>= PERFECT_WIN)
//   FIFO_DEPTH   notes queued per lane, power of 2, >= 2
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   keys[3:0]    lane key levels (1 = held), synchronous to clk
//   song_time    current song position in ms (monotonic)
//   note_valid   chart offers a note
//   note_lane    lane of the offered note
//   note_time    hit time of the offered note in ms
//   note_ready   FIFO of note_lane is not full (combinational from note_lane)
//   judge_valid  one-cycle strobe: a judgement was issued
//   judge_grade  0 = none, 1 = MISS, 2 = GOOD, 3 = PERFECT
//   judge_lane   lane of the judgement (0 while judge_valid is low)
//   score        accumulated score, saturating at 0xFFFFFFFF
//   combo        current combo, saturating at 65535
//   max_combo    highest combo since reset
//
// Note handshake: a note is transferred at a rising clk edge exactly when
// note_valid and note_ready are both high. note_ready depends only on
// note_lane and that lane's fill level; the chart holds the note (valid high,
// data stable) until it is taken, so a full lane never drops a note.
//
// Build option
//   JUDGE_COMBO_BONUS_EN  when defined, PERFECT and GOOD additionally add
//                         min(combo_before, 100). When undefined the bonus
//                         adder does not exist.
// -----------------------------------------------------------------------------
module judge_unit #(
  parameter int PERFECT_WIN = 40,
  parameter int GOOD_WIN    = 100,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  keys,
  input  logic [15:0] song_time,
  input  logic        note_valid,
  input  logic [1:0]  note_lane,
  input  logic [15:0] note_time,
  output logic        note_ready,
  output logic        judge_valid,
  output logic [1:0]  judge_grade,
  output logic [1:0]  judge_lane,
  output logic [31:0] score,
  output logic [15:0] combo,
  output logic [15:0] max_combo
);

  localparam int NUM_LANES = 4;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic signed [16:0] GOOD_S   = 17'(GOOD_WIN);
  localparam logic [16:0]        GOOD_U   = 17'(GOOD_WIN);
  localparam logic [16:0]        PERF_U   = 17'(PERFECT_WIN);

  localparam logic [1:0] GRADE_NONE    = 2'd0;
  localparam logic [1:0] GRADE_MISS    = 2'd1;
  localparam logic [1:0] GRADE_GOOD    = 2'd2;
  localparam logic [1:0] GRADE_PERFECT = 2'd3;

  // ---------------------------------------------------------------------------
  // Per-lane note FIFOs
  // ---------------------------------------------------------------------------
  logic [15:0]      note_mem [NUM_LANES][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr   [NUM_LANES];
  logic [PTR_W-1:0] rd_ptr   [NUM_LANES];
  logic [CNT_W-1:0] fill     [NUM_LANES];

  logic [3:0] push;
  logic [3:0] pop;

  // ---------------------------------------------------------------------------
  // Key edge detection and pending presses
  // ---------------------------------------------------------------------------
  logic [3:0] key_q;
  logic [3:0] press_pend;
  logic [3:0] key_rise;
  logic [3:0] hit_clear;
  logic [3:0] press_pend_n;

  // ---------------------------------------------------------------------------
  // Per-lane event evaluation
  // ---------------------------------------------------------------------------
  logic [15:0]        head     [NUM_LANES];
  logic signed [16:0] diff     [NUM_LANES];
  logic [16:0]        abs_diff [NUM_LANES];
  logic [3:0]         has_note;
  logic [3:0]         expire;
  logic [3:0]         hit;
  logic [3:0]         stray;

  // Service slot
  logic       svc_valid;
  logic [1:0] svc_lane;
  logic       svc_expire;
  logic [1:0] svc_grade;

  // Scoring
  logic [31:0] base_pts;
  logic [31:0] add_pts;
  logic [32:0] score_sum;
  logic [31:0] score_n;
  logic [15:0] combo_n;
  logic [15:0] max_n;

  assign note_ready = (fill[note_lane] != FULL_CNT);

  // Differences are taken in 17-bit signed so neither head + GOOD_WIN nor
  // head - GOOD_WIN can wrap around the 16-bit song clock.
  always_comb begin
    has_note = '0;
    expire   = '0;
    hit      = '0;
    stray    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      head[i]     = note_mem[i][rd_ptr[i]];
      has_note[i] = (fill[i] != '0);
      diff[i]     = $signed({1'b0, song_time}) - $signed({1'b0, head[i]});
      abs_diff[i] = diff[i][16] ? $unsigned(-diff[i]) : $unsigned(diff[i]);
      expire[i]   = has_note[i] && (diff[i] > GOOD_S);
      hit[i]      = press_pend[i] && has_note[i] && (abs_diff[i] <= GOOD_U);
      // A press with nothing in reach is simply dropped; it never competes
      // for the service slot.
      stray[i]    = press_pend[i] && (!has_note[i] || (diff[i] < -GOOD_S));
    end
  end

  // One Expire or Hit serviced per cycle, lane 0 highest priority. Within a
  // lane Expire wins; the press then stays pending for the next head.
  always_comb begin
    svc_valid  = 1'b0;
    svc_lane   = '0;
    svc_expire = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (expire[i] || hit[i]) begin
        svc_valid  = 1'b1;
        svc_lane   = 2'(i);
        svc_expire = expire[i];
      end
    end
  end

  always_comb begin
    svc_grade = GRADE_NONE;
    if (svc_valid) begin
      if (svc_expire) begin
        svc_grade = GRADE_MISS;
      end else if (abs_diff[svc_lane] <= PERF_U) begin
        svc_grade = GRADE_PERFECT;
      end else begin
        svc_grade = GRADE_GOOD;
      end
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      push[i] = note_valid && note_ready && (note_lane == 2'(i));
      pop[i]  = svc_valid && (svc_lane == 2'(i));
    end
  end

  // A fresh rising edge wins over a clear in the same cycle so it is not lost.
  assign key_rise     = keys & ~key_q;
  assign hit_clear    = pop & {4{~svc_expire}};
  assign press_pend_n = (press_pend & ~stray & ~hit_clear) | key_rise;

  // ---------------------------------------------------------------------------
  // Score / combo update
  // ---------------------------------------------------------------------------
  assign base_pts = (svc_grade == GRADE_PERFECT) ? 32'd300 : 32'd100;

`ifdef JUDGE_COMBO_BONUS_EN
  logic [31:0] bonus_pts;
  // Bonus uses the combo before this judgement's increment.
  assign bonus_pts = (combo > 16'd100) ? 32'd100 : {16'd0, combo};
  assign add_pts   = base_pts + bonus_pts;
`else
  assign add_pts   = base_pts;
`endif

  assign score_sum = {1'b0, score} + {1'b0, add_pts};

  always_comb begin
    score_n = score;
    combo_n = combo;
    if (svc_valid) begin
      if (svc_expire) begin
        combo_n = '0;
      end else begin
        score_n = score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];
        combo_n = (combo == 16'hFFFF) ? combo : combo + 16'd1;
      end
    end
    max_n = (combo_n > max_combo) ? combo_n : max_combo;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      press_pend  <= '0;
      judge_valid <= 1'b0;
      judge_grade <= GRADE_NONE;
      judge_lane  <= '0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        fill[i]   <= '0;
      end
    end else begin
      key_q       <= keys;
      press_pend  <= press_pend_n;
      judge_valid <= svc_valid;
      judge_grade <= svc_grade;
      judge_lane  <= svc_valid ? svc_lane : 2'd0;
      score       <= score_n;
      combo       <= combo_n;
      max_combo   <= max_n;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   fill[i] <= fill[i] + 1'b1;
          2'b01:   fill[i] <= fill[i] - 1'b1;
          default: fill[i] <= fill[i];
        endcase
      end
    end
  end

  // Note storage carries no reset; fill levels alone define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push[i]) note_mem[i][wr_ptr[i]] <= note_time;
    end
  end

endmodule
